// File: rtl/alu_pkg.sv
// Shared ALU control encodings and multiply-sequencer FSM state type.
// No logic: constants and types only.
// Imported by the EX-stage multiply datapath and its sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_ADDI = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;
    localparam logic [3:0] ALU_LWSW = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: accumulator, shifting multiplicand/multiplier, result register.
// Latency: one partial product per step_i cycle; result_o loads on the commit_i edge.
// No backpressure: the sequencer drives load/step/commit and owns all flow control.
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             rest_zero_o,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_nxt;

    // Sum is truncated to WIDTH, which gives the low product bits for signed and unsigned alike.
    assign acc_nxt     = acc + (mplier[0] ? mcand : '0);
    assign rest_zero_o = ((mplier >> 1) == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load_i) begin
            acc    <= '0;
            mcand  <= mcand_i;
            mplier <= mplier_i;
        end else if (step_i) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Commit captures the final step's sum directly so the result is ready in the DONE cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_o <= '0;
        end else if (commit_i) begin
            result_o <= acc_nxt;
        end
    end

endmodule

// File: rtl/ex_mul_sequencer.sv
// EX-stage iterative multiply: latches operands on a MUL, stalls the pipe, one bit per cycle.
// Latency: 1 accept + N RUN + 1 DONE cycles (N = WIDTH, or msb(data2)+1 with early termination).
// Backpressure: stall_o holds upstream during accept and RUN; released in DONE as done_o pulses.
module ex_mul_sequencer
    import alu_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         EARLY_TERM = 1,
    parameter logic [3:0] MUL_CTRL   = ALU_MUL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_e       state;
    mul_state_e       state_nxt;
    logic [CNT_W-1:0] count;
    logic             req;
    logic             last_step;
    logic             rest_zero;
    logic             load;
    logic             step;
    logic             commit;

    assign req = start_i & (ALUCtrl_i == MUL_CTRL) & ~flush_i;

    // Early exit once no set multiplier bits remain beyond the one consumed this cycle.
    assign last_step = (count == CNT_W'(WIDTH - 1)) | ((EARLY_TERM != 0) & rest_zero);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    stall_o   = 1'b1;
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (last_step) begin
                        commit    = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            // start_i is ignored here; the instruction that just finished must not re-enter.
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + CNT_W'(1);
        end
    end

    assign busy_o = (state != ST_IDLE);
    assign done_o = (state == ST_DONE);

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load),
        .step_i      (step),
        .commit_i    (commit),
        .mcand_i     (data1_i),
        .mplier_i    (data2_i),
        .rest_zero_o (rest_zero),
        .result_o    (result_o)
    );

endmodule
